iobus_responder: RTL
====================

# iobus_responder

- Fast-side responder for CPU cycles that the chip-select decoder routes to the slow I/O bus.
- Posted video-RAM writes are acknowledged at once and queued in a small FIFO. All other I/O cycles are blocking.
- A blocking cycle first drains the FIFO, then runs one downstream request/acknowledge transaction, then terminates the CPU cycle.
- The block sits between the decoder (IOCS/IOPWCS) and the I/O-bus master engine.

## Interface
Parameters:
- DEPTH, 4, posted-write FIFO entries; power of two, 2..16.

Ports:
- CLK  in  1  system clock; single clock domain.
- nRES  in  1  reset, synchronous and active-low.
- BACT  in  1  CPU bus cycle active; high from address strobe until cycle end.
- IOCS  in  1  decoder: cycle targets the I/O bus.
- IOPWCS  in  1  decoder: cycle is a postable video-RAM write; takes priority over IOCS.
- A  in  23  CPU address [23:1].
- D  in  16  CPU write data.
- nWE  in  1  CPU write strobe, low = write.
- nUDS, nLDS  in  1 each  CPU byte strobes.
- CPUACK  out  1  cycle may terminate; held until BACT falls.
- CPURD  out  16  read data latched from downstream.
- IOREQ  out  1  downstream request; level.
- IOA  out  23  downstream address.
- IOD  out  16  downstream write data.
- IOWE  out  1  downstream write.
- IOBE  out  2  downstream byte enables {upper, lower}, active-high.
- IOACK  in  1  downstream completion; one-cycle pulse.
- IORD  in  16  downstream read data; valid with IOACK.
- PWPEND  out  1  FIFO non-empty.

## Operation
CPU-side FSM states: IDLE, POST, DRAIN, DIRECT, ACK.
- IDLE: BACT=1 and IOPWCS=1 → POST. BACT=1, IOCS=1, IOPWCS=0 → DRAIN. Otherwise remain in IDLE (cycle belongs to another target).
- POST: if the FIFO is not full, push {A, D, ~nUDS, ~nLDS} and go to ACK. If full, wait. If BACT falls while waiting, go to IDLE with no push.
- DRAIN: wait until the FIFO is empty and no downstream transaction is in flight, then go to DIRECT. BACT fall → IDLE.
- DIRECT: drive IOREQ with the CPU address/data/nWE. On IOACK, latch IORD into CPURD (reads only), drop IOREQ, go to ACK. Once IOREQ is raised, the transaction completes even if BACT falls; in that case go to IDLE without CPUACK.
- ACK: CPUACK=1. Go to IDLE when BACT=0.

Downstream issue rules:
- FIFO head has priority and is issued whenever the FIFO is non-empty and no transaction is in flight; IOWE=1.
- A direct request is issued only with the FIFO empty, which preserves write ordering.
- IOREQ stays high with IOA/IOD/IOWE/IOBE stable until the IOACK cycle. It is low the cycle after IOACK, for at least one cycle between transactions.

FIFO:
- Pop on IOACK of a FIFO-sourced transaction.
- Push and pop in the same cycle are legal when not full; count is unchanged.
- A push is evaluated against the registered count, so a full FIFO accepts the next push one cycle after the pop.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.

## Timing
- Reset values: CPUACK=0, IOREQ=0, IOA=0, IOD=0, IOWE=0, IOBE=0, CPURD=0, PWPEND=0, FSM=IDLE, FIFO empty.
- Reset mid-operation discards queued posted writes and drops IOREQ at the next edge. The downstream engine must abort on IOREQ fall.
- Posted write, FIFO not full: BACT/IOPWCS seen at edge n → POST; push and ACK at n+1; CPUACK high from n+1.
- Direct cycle, FIFO empty: DRAIN at n → DIRECT and IOREQ high at n+1. IOACK at edge m → CPUACK and CPURD valid at m+1.
- FIFO head issue: IOREQ high one cycle after the entry becomes head with the engine idle.

## Configuration
- IOBR_POSTED_WRITE_EN defined: behaviour as above.
- Undefined: IOPWCS is ignored, so every IOCS cycle is blocking. There is no FIFO and no POST state. PWPEND is tied 0. The DRAIN→DIRECT transition depends only on the engine being idle.

## Structure
- Package iobr_pkg: state enum; entry struct {addr[23:1], data[15:0], be[1:0]}; DEPTH default constant.
- Sub-module iobr_fifo: synchronous FIFO with count, full, empty, push, pop and head outputs.

## Test plan
- Reset with nRES=0 for 2 cycles mid-DIRECT → all outputs 0 next edge; IOREQ low; PWPEND=0.
- Three posted writes to 3FA100/3FA102/3FA104 with IOACK held off → CPUACK each within 1 cycle of POST. Then IOACK pulses → IOA issued in order, PWPEND=0 after the third.
- Five posted writes with DEPTH=4 and no IOACK → fifth stalls in POST. One IOACK → fifth pushed the cycle after the pop, then CPUACK.
- Two posted writes, then a read of E1FE with IOCS=1 → read IOREQ only after both FIFO IOACKs. IORD=A5C3 → CPURD=A5C3, CPUACK next cycle.
- BACT falls during DIRECT before IOACK → transaction completes, CPUACK never asserts, FSM returns to IDLE.
- IOBR_POSTED_WRITE_EN undefined, IOPWCS=1 with IOCS=1 write → blocking DIRECT cycle; CPUACK only after IOACK.

Source files
------------

// File: rtl/iobr_pkg.sv
// Shared types and defaults for the I/O-bus responder: CPU-side FSM states
// and the posted-write FIFO entry layout.
package iobr_pkg;

    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POST   = 3'd1,
        S_DRAIN  = 3'd2,
        S_DIRECT = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    typedef struct packed {
        logic [23:1] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/iobr_fifo.sv
// Synchronous FIFO for posted video-RAM writes. Fullness is judged on the
// registered count, so a full FIFO takes a new entry only after a pop has landed.
module iobr_fifo
    import iobr_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [ENTRY_W-1:0]      wdata,
    output logic [ENTRY_W-1:0]      head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries below the count are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/iobus_responder.sv
// Fast-side responder for CPU cycles routed to the slow I/O bus.
// Define IOBR_POSTED_WRITE_EN to enable posted video-RAM writes through iobr_fifo.
module iobus_responder
    import iobr_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRES,
    input  logic        BACT,
    input  logic        IOCS,
    input  logic        IOPWCS,
    input  logic [23:1] A,
    input  logic [15:0] D,
    input  logic        nWE,
    input  logic        nUDS,
    input  logic        nLDS,
    output logic        CPUACK,
    output logic [15:0] CPURD,
    output logic        IOREQ,
    output logic [23:1] IOA,
    output logic [15:0] IOD,
    output logic        IOWE,
    output logic [1:0]  IOBE,
    input  logic        IOACK,
    input  logic [15:0] IORD,
    output logic        PWPEND,
    output logic [2:0]  fsm_state
);

    state_t state;
    logic   src_fifo;
    logic   aborted;
    logic   fifo_empty;
    entry_t head;
    logic   ack_now;
    logic   issue_fifo;
    logic   issue_direct;

    // Handshake: IOREQ is a level held with stable IOA/IOD/IOWE/IOBE until the
    // cycle where IOACK is seen; it is low for at least one cycle before the next.
    assign ack_now      = IOREQ && IOACK;
    assign issue_fifo   = !IOREQ && !fifo_empty;
    assign issue_direct = (state == S_DRAIN) && BACT && !IOREQ && fifo_empty;
    assign fsm_state    = state;

`ifdef IOBR_POSTED_WRITE_EN
    logic                   fifo_full;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [ENTRY_W-1:0]     head_bits;
    entry_t                 cpu_entry;

    assign cpu_entry = '{addr: A, data: D, be: {~nUDS, ~nLDS}};
    assign fifo_push = (state == S_POST) && BACT && !fifo_full;
    assign fifo_pop  = ack_now && src_fifo;
    assign head      = head_bits;
    assign PWPEND    = (fifo_count != '0);

    iobr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nRES),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cpu_entry),
        .head  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
`else
    localparam int unused_depth = DEPTH;
    logic [1:0] unused_sigs;

    assign fifo_empty  = 1'b1;
    assign head        = '0;
    assign PWPEND      = 1'b0;
    assign unused_sigs = {IOPWCS, src_fifo};
`endif

    always_ff @(posedge CLK) begin
        if (!nRES) begin
            state   <= S_IDLE;
            CPUACK  <= 1'b0;
            CPURD   <= '0;
            aborted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    aborted <= 1'b0;
`ifdef IOBR_POSTED_WRITE_EN
                    if (BACT && IOPWCS) begin
                        state <= S_POST;
                    end else if (BACT && IOCS) begin
                        state <= S_DRAIN;
                    end
`else
                    if (BACT && IOCS) begin
                        state <= S_DRAIN;
                    end
`endif
                end
`ifdef IOBR_POSTED_WRITE_EN
                S_POST: begin
                    if (!BACT) begin
                        state <= S_IDLE;
                    end else if (!fifo_full) begin
                        state  <= S_ACK;
                        CPUACK <= 1'b1;
                    end
                end
`endif
                S_DRAIN: begin
                    if (!BACT) begin
                        state <= S_IDLE;
                    end else if (issue_direct) begin
                        state <= S_DIRECT;
                    end
                end
                // A raised request always runs to IOACK; a CPU that left early gets no ack.
                S_DIRECT: begin
                    if (!BACT) begin
                        aborted <= 1'b1;
                    end
                    if (ack_now) begin
                        if (!IOWE) begin
                            CPURD <= IORD;
                        end
                        if (aborted || !BACT) begin
                            state <= S_IDLE;
                        end else begin
                            state  <= S_ACK;
                            CPUACK <= 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    if (!BACT) begin
                        state  <= S_IDLE;
                        CPUACK <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    CPUACK <= 1'b0;
                end
            endcase
        end
    end

    // FIFO head wins over a direct request, which keeps posted writes ordered.
    always_ff @(posedge CLK) begin
        if (!nRES) begin
            IOREQ    <= 1'b0;
            IOA      <= '0;
            IOD      <= '0;
            IOWE     <= 1'b0;
            IOBE     <= '0;
            src_fifo <= 1'b0;
        end else if (ack_now) begin
            IOREQ <= 1'b0;
        end else if (issue_fifo) begin
            IOREQ    <= 1'b1;
            IOA      <= head.addr;
            IOD      <= head.data;
            IOWE     <= 1'b1;
            IOBE     <= head.be;
            src_fifo <= 1'b1;
        end else if (issue_direct) begin
            IOREQ    <= 1'b1;
            IOA      <= A;
            IOD      <= D;
            IOWE     <= ~nWE;
            IOBE     <= {~nUDS, ~nLDS};
            src_fifo <= 1'b0;
        end
    end

endmodule
